// File: rtl/crc8_transmitter.sv
// Serial CRC-8 generator: accepts a payload over valid/ready, shifts it MSB first
// through an LFSR and presents {payload, crc} until the downstream takes it.
module crc8_transmitter #(
  parameter int                 BW     = 40,
  parameter int                 CRC_BW = 8,
  parameter logic [CRC_BW-1:0]  POLY   = 8'h07
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BW+CRC_BW-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [BW-1:0]       data_q;
  logic [BW-1:0]       sh;
  logic [CRC_BW-1:0]   crc;
  logic [CRC_BW-1:0]   crc_next;
  logic [CW-1:0]       cnt;
  logic                fb;
  logic                last_bit;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign last_bit = (cnt == CW'(BW - 1));

  // One LFSR step: feedback is the CRC MSB xor the next payload bit.
  assign fb       = crc[CRC_BW-1] ^ sh[BW-1];
  assign crc_next = {crc[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      sh        <= '0;
      crc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            sh     <= in_data;
            crc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          crc <= crc_next;
          sh  <= {sh[BW-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          // The final bit's CRC goes straight into the codeword, saving a cycle.
          if (last_bit) begin
            out       <= {data_q, crc_next};
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_transmitter.sv
// Directed bench for crc8_transmitter: table of 8-bit payloads with known CRC-8 codewords,
// the "123456789" check value on a 72-bit instance, backpressure and mid-frame reset.
module tb_crc8_transmitter;

  logic        clk;
  logic        rstn;

  logic [7:0]  d8_in_data;
  logic        d8_in_valid;
  logic        d8_in_ready;
  logic [15:0] d8_out;
  logic        d8_out_valid;
  logic        d8_out_ready;
  logic        d8_busy;

  logic [71:0] d72_in_data;
  logic        d72_in_valid;
  logic        d72_in_ready;
  logic [79:0] d72_out;
  logic        d72_out_valid;
  logic        d72_out_ready;
  logic        d72_busy;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [7:0]  payload;
    logic [15:0] expected;
  } vector_t;

  vector_t vectors[8];

  crc8_transmitter #(.BW(8)) dut8 (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (d8_in_data),
    .in_valid  (d8_in_valid),
    .in_ready  (d8_in_ready),
    .out       (d8_out),
    .out_valid (d8_out_valid),
    .out_ready (d8_out_ready),
    .busy      (d8_busy)
  );

  crc8_transmitter #(.BW(72)) dut72 (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (d72_in_data),
    .in_valid  (d72_in_valid),
    .in_ready  (d72_in_ready),
    .out       (d72_out),
    .out_valid (d72_out_valid),
    .out_ready (d72_out_ready),
    .busy      (d72_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [79:0] actual, input logic [79:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // Long division of the 16-bit codeword by x^8+x^2+x+1; a valid codeword leaves 0.
  function automatic logic [7:0] remainder16(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return r[7:0];
  endfunction

  // Hands one payload to the 8-bit instance; returns edges from accept to out_valid.
  task automatic apply_stimulus(input logic [7:0] payload, output int latency);
    @(negedge clk);
    d8_in_data  = payload;
    d8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d8_in_valid = 1'b0;
    d8_in_data  = ~payload;
    latency = 0;
    while (!d8_out_valid && latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    logic [71:0] p72;

    vectors[0] = '{8'h01, 16'h0107};
    vectors[1] = '{8'h00, 16'h0000};
    vectors[2] = '{8'h80, 16'h8089};
    vectors[3] = '{8'hFF, 16'hFFF3};
    vectors[4] = '{8'h02, 16'h020E};
    vectors[5] = '{8'h55, 16'h55AC};
    vectors[6] = '{8'hA5, 16'hA572};
    vectors[7] = '{8'h10, 16'h1070};

    rstn          = 1'b0;
    d8_in_data    = '0;
    d8_in_valid   = 1'b0;
    d8_out_ready  = 1'b1;
    d72_in_data   = '0;
    d72_in_valid  = 1'b0;
    d72_out_ready = 1'b1;

    #12;
    check_output("reset out",       80'(d8_out),       80'h0);
    check_output("reset out_valid", 80'(d8_out_valid), 80'h0);
    check_output("reset busy",      80'(d8_busy),      80'h0);
    check_output("reset in_ready",  80'(d8_in_ready),  80'h1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vectors[i].payload, lat);
      check_output($sformatf("latency v%0d", i), 80'(lat), 80'd8);
      check_output($sformatf("codeword v%0d", i), 80'(d8_out), 80'(vectors[i].expected));
      check_output($sformatf("busy in DONE v%0d", i), 80'(d8_busy), 80'h1);
      @(posedge clk);
      #1;
      check_output($sformatf("pulse end v%0d", i), 80'(d8_out_valid), 80'h0);
      check_output($sformatf("back to IDLE v%0d", i), 80'(d8_in_ready), 80'h1);
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0]  p;
      logic [15:0] flipped;
      p = 8'($urandom);
      apply_stimulus(p, lat);
      check_output($sformatf("rand latency %0d", i), 80'(lat), 80'd8);
      check_output($sformatf("rand payload %0d", i), 80'(d8_out[15:8]), 80'(p));
      check_output($sformatf("rand remainder %0d", i), 80'(remainder16(d8_out)), 80'h0);
      flipped = d8_out ^ (16'h1 << $urandom_range(15, 0));
      check_output($sformatf("rand flip detect %0d", i), 80'(remainder16(flipped) != 8'h00), 80'h1);
      @(posedge clk);
      #1;
    end

    // Backpressure: DONE holds through 20 cycles while the source pokes in_valid.
    d8_out_ready = 1'b0;
    apply_stimulus(8'h55, lat);
    check_output("bp latency", 80'(lat), 80'd8);
    held = d8_out;
    check_output("bp codeword", 80'(held), 80'h55AC);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      d8_in_valid = c[0];
      d8_in_data  = 8'(c * 7 + 3);
      @(posedge clk);
      #1;
      check_output($sformatf("bp out stable c%0d", c), 80'(d8_out), 80'(held));
      check_output($sformatf("bp out_valid c%0d", c), 80'(d8_out_valid), 80'h1);
      check_output($sformatf("bp in_ready c%0d", c), 80'(d8_in_ready), 80'h0);
    end
    @(negedge clk);
    d8_in_valid  = 1'b0;
    d8_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp release out_valid", 80'(d8_out_valid), 80'h0);
    check_output("bp release in_ready", 80'(d8_in_ready), 80'h1);
    apply_stimulus(8'hA5, lat);
    check_output("bp next latency", 80'(lat), 80'd8);
    check_output("bp next codeword", 80'(d8_out), 80'hA572);
    @(posedge clk);
    #1;

    // Reset between edges three bits into a frame must clear outputs at once.
    @(negedge clk);
    d8_in_data  = 8'hFF;
    d8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d8_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_output("pre-reset busy", 80'(d8_busy), 80'h1);
    rstn = 1'b0;
    #1;
    check_output("mid reset busy",      80'(d8_busy),      80'h0);
    check_output("mid reset in_ready",  80'(d8_in_ready),  80'h1);
    check_output("mid reset out_valid", 80'(d8_out_valid), 80'h0);
    check_output("mid reset out",       80'(d8_out),       80'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (d8_out_valid) break;
    end
    check_output("aborted frame silent", 80'(d8_out_valid), 80'h0);
    apply_stimulus(8'h02, lat);
    check_output("post reset latency", 80'(lat), 80'd8);
    check_output("post reset codeword", 80'(d8_out), 80'h020E);

    // Standard CRC-8 check value over ASCII "123456789".
    p72 = 72'h313233343536373839;
    @(negedge clk);
    d72_in_data  = p72;
    d72_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d72_in_valid = 1'b0;
    d72_in_data  = '0;
    lat = 0;
    while (!d72_out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output("bw72 latency", 80'(lat), 80'd72);
    check_output("bw72 crc", 80'(d72_out[7:0]), 80'hF4);
    check_output("bw72 payload", 80'(d72_out[79:8]), 80'(p72));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/crc8_transmitter.md
Name: crc8_transmitter

Overview:
- Transmit-side counterpart to the CRC-8 checking receiver.
- Accepts a BW-bit payload over a valid/ready handshake and computes the CRC serially, one bit per cycle, MSB first, with an LFSR.
- Presents the codeword {payload, crc} so the receiver's full-word remainder check evaluates to zero.
- Sits between the payload source and the channel/receiver.

Parameters:
- BW, 40, payload width in bits (≥2).
- CRC_BW, 8, CRC width in bits.
- POLY, 8'h07, generator polynomial without the implicit x^CRC_BW term (x^8+x^2+x+1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  BW  payload to protect.
- in_valid  input  1  payload valid.
- in_ready  output  1  block can accept a payload.
- out  output  BW+CRC_BW  codeword; payload in [BW+CRC_BW-1:CRC_BW], CRC in [CRC_BW-1:0].
- out_valid  output  1  codeword valid.
- out_ready  input  1  downstream accepts the codeword.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rstn low, asynchronous, any state):
  - State goes to IDLE.
  - out=0, out_valid=0, busy=0, in_ready=1.
  - Internal CRC, shift and bit-counter registers cleared.
- CRC algorithm: init 0, no reflection, no final XOR.
  - Per bit: fb = crc[CRC_BW-1] ^ sh[BW-1].
  - crc_next = {crc[CRC_BW-2:0],1'b0} ^ (fb ? POLY : 0).
  - sh shifts left by 1.
- FSM IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T: latch in_data into data_q and into shift register sh; crc<=0; cnt<=0; go to CALC.
- FSM CALC:
  - in_ready=0, busy=1.
  - Each edge processes one bit and increments cnt.
  - On the edge processing bit index BW-1 (cnt==BW-1): out<={data_q, crc_next}; out_valid<=1; go to DONE.
  - out_valid therefore rises at edge T+BW.
- FSM DONE:
  - out_valid=1 and out held stable; in_ready=0.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - out keeps its last value and is don't-care while out_valid=0.
- Throughput: one codeword per BW+2 cycles minimum (accept, BW calc edges, handoff).
- in_valid outside IDLE is ignored; the source must hold in_data until the handshake.
- Once asserted, out_valid is never dropped without out_ready. Backpressure of any length holds DONE.
- out_ready while out_valid=0 has no effect.
- Reset during CALC or DONE aborts the frame; no partial codeword is emitted.
- in_data is sampled only on the accepting edge; later changes do not affect the CRC.

Test Plan:
- BW=8, in_data=8'h01, out_ready=1 -> out_valid at accept+8 edges; out=16'h0107; one-cycle pulse.
- BW=8, sweep 8'h00/8'h80/8'hFF -> out=16'h0000 / 16'h8089 / 16'hFFF3.
- BW=72, in_data=72'h313233343536373839 ("123456789") -> out[7:0]=8'hF4, out[79:8]=in_data.
- Default BW=40, random payloads with the CRC-8 receiver connected -> receiver remainder 0 and its out equals payload after its latency. Flipping any single out bit -> receiver out=0.
- Backpressure: out_ready=0 for 20 cycles in DONE, in_valid toggling -> out and out_valid stable, in_ready=0, no new accept. Release -> IDLE next edge, next payload accepted.
- Assert rstn=0 mid-CALC (cnt=3) between clock edges -> outputs clear immediately, without waiting for an edge. After release, a fresh payload gives the correct CRC.
